// File: rtl/voice_echo_gen.sv
`default_nettype none
// ============================================================================
//  Module      : voice_echo_gen
//  Description : Single-tap audio echo generator. Accepted samples go into a
//                circular delay line of DELAY_DEPTH entries. While the line
//                is still filling, input passes straight through. Once it is
//                full, each output is the input plus the attenuated sample
//                from DELAY_DEPTH accepts earlier, saturated to DATA_WIDTH.
//                Optional build macro: ECHO_FEEDBACK_EN. When it is defined,
//                the saturated output is written back to the delay line, so
//                echoes repeat and decay. When it is undefined, the raw input
//                is stored and only a single echo is produced.
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_echo_gen #(
    parameter int DATA_WIDTH  = 16,
    parameter int DELAY_DEPTH = 1024,
    parameter int ATTN_SHIFT  = 1
) (
    input  logic                         sck,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         data_in_valid,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         data_out_valid,
    output logic                         echo_active
);

    localparam int c_PTR_W = $clog2(DELAY_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    // Count value of the accept that completes the fill.
    localparam logic [c_CNT_W-1:0] c_FILL_LAST = c_CNT_W'(DELAY_DEPTH - 1);

    localparam logic signed [DATA_WIDTH-1:0] c_SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] c_SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_ECHO = 1'b1
    } state_t;

    state_t                         r_state;
    logic        [c_PTR_W-1:0]      r_wr_ptr;
    logic        [c_CNT_W-1:0]      r_fill_cnt;
    logic signed [DATA_WIDTH-1:0]   r_data_out;
    logic                           r_data_out_valid;
    logic                           r_echo_active;

    // The delay line is not reset; the FILL phase overwrites every entry
    // before any entry is read as an echo.
    logic signed [DATA_WIDTH-1:0]   r_mem [DELAY_DEPTH];

    logic signed [DATA_WIDTH-1:0]   w_delayed;
    logic signed [DATA_WIDTH-1:0]   w_echo;
    logic signed [DATA_WIDTH:0]     w_sum;
    logic signed [DATA_WIDTH-1:0]   w_sat;
    logic signed [DATA_WIDTH-1:0]   w_next_out;
    logic signed [DATA_WIDTH-1:0]   w_store;

    // Read the delayed sample, attenuate it, add it to the input and saturate.
    always_comb begin
        w_delayed = r_mem[r_wr_ptr];
        w_echo    = w_delayed >>> ATTN_SHIFT;
        w_sum     = {data_in[DATA_WIDTH-1], data_in} + {w_echo[DATA_WIDTH-1], w_echo};
        // Overflow shows up as disagreement between the two top sum bits.
        if (w_sum[DATA_WIDTH] != w_sum[DATA_WIDTH-1]) begin
            w_sat = w_sum[DATA_WIDTH] ? c_SAT_MIN : c_SAT_MAX;
        end else begin
            w_sat = w_sum[DATA_WIDTH-1:0];
        end
    end

    // Select the output sample and the value written back to the delay line.
    always_comb begin
        w_next_out = data_in;
        w_store    = data_in;
        if (r_state == ST_ECHO) begin
            w_next_out = w_sat;
`ifdef ECHO_FEEDBACK_EN
            w_store    = w_sat;
`else
            w_store    = data_in;
`endif
        end
    end

    // Write the delay line on each accepted sample.
    always_ff @(posedge sck) begin
        if (rst_n && data_in_valid) begin
            r_mem[r_wr_ptr] <= w_store;
        end
    end

    // Control FSM: FILL counts accepted samples; the accept that completes the
    // fill switches to ECHO, which then holds until reset.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_FILL;
            r_wr_ptr         <= '0;
            r_fill_cnt       <= '0;
            r_data_out       <= '0;
            r_data_out_valid <= 1'b0;
            r_echo_active    <= 1'b0;
        end else begin
            r_data_out_valid <= data_in_valid;
            if (data_in_valid) begin
                r_data_out <= w_next_out;
                r_wr_ptr   <= r_wr_ptr + c_PTR_W'(1);
                case (r_state)
                    ST_FILL: begin
                        r_fill_cnt <= r_fill_cnt + c_CNT_W'(1);
                        if (r_fill_cnt == c_FILL_LAST) begin
                            r_state       <= ST_ECHO;
                            r_echo_active <= 1'b1;
                        end
                    end
                    ST_ECHO: begin
                        r_echo_active <= 1'b1;
                    end
                    default: begin
                        r_state       <= ST_FILL;
                        r_echo_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out       = r_data_out;
    assign data_out_valid = r_data_out_valid;
    assign echo_active    = r_echo_active;

endmodule
`default_nettype wire

// File: tb/tb_voice_echo_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_voice_echo_gen
//  Description : Directed self-checking bench for voice_echo_gen with
//                DATA_WIDTH=16, DELAY_DEPTH=4, ATTN_SHIFT=1. Expected values
//                are hand-computed. Where the two builds differ, the expected
//                values follow ECHO_FEEDBACK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_voice_echo_gen;

    logic               sck;
    logic               rst_n;
    logic signed [15:0] data_in;
    logic               data_in_valid;
    logic signed [15:0] data_out;
    logic               data_out_valid;
    logic               echo_active;

    int n_tests = 0;
    int n_fail  = 0;

    voice_echo_gen #(
        .DATA_WIDTH  (16),
        .DELAY_DEPTH (4),
        .ATTN_SHIFT  (1)
    ) dut (
        .sck            (sck),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .echo_active    (echo_active)
    );

    initial sck = 1'b0;
    always #5 sck = ~sck;

    // Impulse response: 1000 followed by zeros.
`ifdef ECHO_FEEDBACK_EN
    int c_imp_exp [13] = '{1000, 0, 0, 0, 500, 0, 0, 0, 250, 0, 0, 0, 125};
`else
    int c_imp_exp [13] = '{1000, 0, 0, 0, 500, 0, 0, 0, 0, 0, 0, 0, 0};
`endif

    task automatic check(input string tag, input logic signed [31:0] observed,
                         input logic signed [31:0] expected);
        n_tests++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One accepted sample; the outputs are then sampled 1 ns after the edge.
    task automatic send(input int v);
        data_in       = 16'(v);
        data_in_valid = 1'b1;
        @(posedge sck);
        #1;
    endtask

    task automatic idle();
        data_in_valid = 1'b0;
        @(posedge sck);
        #1;
    endtask

    task automatic do_reset();
        data_in_valid = 1'b0;
        data_in       = '0;
        rst_n         = 1'b0;
        repeat (2) @(posedge sck);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        data_in       = '0;
        data_in_valid = 1'b0;

        // Reset state
        do_reset();
        check("rst_data_out", data_out, 0);
        check("rst_valid", data_out_valid, 0);
        check("rst_echo_active", echo_active, 0);

        // Impulse response, back-to-back valid
        for (int i = 0; i < 13; i++) begin
            send(i == 0 ? 1000 : 0);
            check($sformatf("imp_out[%0d]", i), data_out, c_imp_exp[i]);
            check($sformatf("imp_valid[%0d]", i), data_out_valid, 1);
            check($sformatf("imp_echo_active[%0d]", i), echo_active, (i >= 3) ? 1 : 0);
        end
        idle();
        check("imp_valid_drop", data_out_valid, 0);

        // In-range sums after a non-trivial fill
        do_reset();
        send(100); send(200); send(300); send(400);
        check("fill_passthru_last", data_out, 400);
        send(10);
        check("sum_0", data_out, 60);
        send(20);
        check("sum_1", data_out, 120);
        send(-1000);
        check("sum_2", data_out, -850);
        idle();

        // Positive saturation
        do_reset();
        repeat (4) send(30000);
        check("sat_fill", data_out, 30000);
        for (int i = 0; i < 4; i++) begin
            send(30000);
            check($sformatf("sat_pos[%0d]", i), data_out, 32767);
        end
        idle();

        // Negative saturation
        do_reset();
        repeat (4) send(-30000);
        for (int i = 0; i < 4; i++) begin
            send(-30000);
            check($sformatf("sat_neg[%0d]", i), data_out, -32768);
        end
        idle();

        // Gapped valid: one accept every third cycle
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(i == 0 ? 1000 : 0);
            check($sformatf("gap_out[%0d]", i), data_out, (i == 0) ? 1000 : ((i == 4) ? 500 : 0));
            check($sformatf("gap_valid[%0d]", i), data_out_valid, 1);
            for (int k = 0; k < 2; k++) begin
                idle();
                check($sformatf("gap_hold[%0d.%0d]", i, k), data_out,
                      (i == 0) ? 1000 : ((i == 4) ? 500 : 0));
                check($sformatf("gap_novalid[%0d.%0d]", i, k), data_out_valid, 0);
            end
        end

        // Asynchronous reset mid-stream, then refill
        do_reset();
        for (int i = 1; i <= 6; i++) send(i * 1000);
        check("pre_abort_echo_active", echo_active, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_data_out", data_out, 0);
        check("abort_valid", data_out_valid, 0);
        check("abort_echo_active", echo_active, 0);
        @(posedge sck);
        #1;
        rst_n = 1'b1;
        send(100);
        check("refill_0", data_out, 100);
        send(-200);
        check("refill_1", data_out, -200);
        send(300);
        check("refill_2", data_out, 300);
        check("refill_echo_off", echo_active, 0);
        send(-400);
        check("refill_3", data_out, -400);
        check("refill_echo_on", echo_active, 1);
        send(0);
        check("refill_first_echo", data_out, 50);
        idle();

        // Negative echo rounds toward minus infinity
        do_reset();
        repeat (4) send(0);
        send(-1001);
        check("neg_imp", data_out, -1001);
        repeat (3) send(0);
        send(0);
        check("neg_echo", data_out, -501);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/voice_echo_gen.md
VOICE_ECHO_GEN -- requirements
Module: voice_echo_gen

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, the signed sample width.
REQ-002 The block SHALL have parameter DELAY_DEPTH, default 1024, the echo delay in accepted samples (power of two, minimum 4).
REQ-003 The block SHALL have parameter ATTN_SHIFT, default 1, the echo attenuation as an arithmetic right shift (gain 2^-ATTN_SHIFT).
REQ-004 sck  input  1  sample clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 data_in  input  DATA_WIDTH  signed input sample.
REQ-007 data_in_valid  input  1  data_in accepted on each sck edge while high.
REQ-008 data_out  output  DATA_WIDTH  signed echoed sample, registered.
REQ-009 data_out_valid  output  1  high for one cycle per accepted input.
REQ-010 echo_active  output  1  high once the delay line holds DELAY_DEPTH samples.

Function
REQ-011 The block SHALL hold a circular delay line of DELAY_DEPTH x DATA_WIDTH entries, addressed by a wrapping write pointer of log2(DELAY_DEPTH) bits.
REQ-012 On each accepted sample, the entry at the write pointer SHALL be read as delayed sample d, overwritten with the stored value, and the pointer incremented modulo DELAY_DEPTH.
REQ-013 The state machine SHALL have two states: FILL (reset state) and ECHO.
REQ-014 In FILL, a fill counter SHALL count accepted samples; the accept that brings it to DELAY_DEPTH SHALL move the state to ECHO at that edge.
REQ-015 In FILL, data_out SHALL equal data_in (pass-through); echo_active SHALL be 0.
REQ-016 In ECHO, data_out SHALL equal sat(data_in + (d >>> ATTN_SHIFT)), with the sum computed at DATA_WIDTH+1 bits; echo_active SHALL be 1.
REQ-017 sat() SHALL clamp to +(2^(DATA_WIDTH-1))-1 and -(2^(DATA_WIDTH-1)) and pass in-range values unchanged.
REQ-018 Latency SHALL be exactly one cycle: data_out and data_out_valid update on the edge that accepts data_in.
REQ-019 While data_in_valid is low, data_out SHALL hold, data_out_valid SHALL be 0, and the pointer, counter and memory SHALL be unchanged.
REQ-020 Back-to-back valid samples on every cycle SHALL be supported with no stall.
REQ-021 The state SHALL remain ECHO until reset; pointer wrap SHALL NOT change state.

Reset
REQ-022 On rst_n low: data_out=0, data_out_valid=0, echo_active=0, state=FILL, write pointer=0, fill counter=0.
REQ-023 Delay-line contents SHALL NOT need a reset; FILL guarantees stale entries are never used.
REQ-024 Reset asserted mid-stream SHALL abort immediately; after release the block SHALL refill for DELAY_DEPTH samples before any echo appears.

Configuration
REQ-025 With macro ECHO_FEEDBACK_EN defined, the stored value SHALL be the saturated data_out (recursive, decaying repeated echoes).
REQ-026 Without ECHO_FEEDBACK_EN, the stored value SHALL be data_in (single echo, feed-forward).
REQ-027 In FILL, the stored value SHALL be data_in in both builds.

Verification (DATA_WIDTH=16, DELAY_DEPTH=4, ATTN_SHIFT=1)
REQ-028 Impulse: 1000 then 0s, feed-forward build -> outputs 1000,0,0,0,500,0,0,0,0...; echo_active rises on the edge accepting the 4th sample.
REQ-029 Impulse, ECHO_FEEDBACK_EN build -> 1000,0,0,0,500,0,0,0,250,0,0,0,125...
REQ-030 Saturation: constant 30000 after fill -> data_out 32767 (30000+15000 clamped); constant -30000 -> -32768.
REQ-031 Gapped valid: valid high every 3rd cycle with impulse 1000 -> echo 500 on the 5th accepted sample, data_out held between strobes, data_out_valid only on accepts.
REQ-032 Reset mid-stream after 6 samples -> all outputs 0 on assert; after release the next 4 outputs equal inputs exactly (no stale echo).
REQ-033 Negative shift: impulse -1001 after fill -> echo -501 (arithmetic shift rounds toward minus infinity).
